// File: rtl/pcm_interp_dither_pkg.sv
// Shared constants for the PCM interpolator and its dither source.
package pcm_interp_dither_pkg;

    // Galois feedback mask for x^16+x^14+x^13+x^11+1.
    localparam logic [15:0] LFSR_TAPS         = 16'hB400;
    // Default dither LFSR seed; any nonzero value works.
    localparam logic [15:0] LFSR_SEED_DEFAULT = 16'hACE1;

    localparam int OSR_LOG2_DEFAULT = 6;
    localparam int OSR              = 1 << OSR_LOG2_DEFAULT;

    // Oversampling ratio for an arbitrary log2 setting.
    function automatic int osr_of(input int log2);
        return 1 << log2;
    endfunction

endpackage

// File: rtl/lfsr16_dither.sv
// 16-bit Galois LFSR producing a gated 1-bit dither stream.
module lfsr16_dither
    import pcm_interp_dither_pkg::*;
#(
    parameter logic [15:0] SEED = LFSR_SEED_DEFAULT,
    parameter logic [15:0] TAPS = LFSR_TAPS
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic dither
);

    logic [15:0] lfsr_q;
    logic [15:0] lfsr_d;

    // Shift right and fold the tap mask in when the outgoing bit is set.
    always_comb begin
        lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? TAPS : 16'h0000);
    end

    // Free-running state; the enable only gates the output.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) lfsr_q <= SEED;
        else     lfsr_q <= lfsr_d;
    end

    assign dither = en & lfsr_q[0];

endmodule

// File: rtl/pcm_interp_dither.sv
// Audio-rate PCM to modulator-rate linear interpolator with dither output.
module pcm_interp_dither
    import pcm_interp_dither_pkg::*;
#(
    parameter int          DATA_WIDTH = 16,
    parameter int          OSR_LOG2   = OSR_LOG2_DEFAULT,
    parameter logic [15:0] LFSR_SEED  = LFSR_SEED_DEFAULT
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic signed [DATA_WIDTH-1:0] s_data,
    input  logic                         s_valid,
    output logic                         s_ready,
    input  logic                         dither_en,
    output logic signed [DATA_WIDTH-1:0] out_data,
    output logic                         out_dither,
    output logic                         underrun,
    input  logic                         underrun_clr
);

    localparam int AW    = DATA_WIDTH + OSR_LOG2 + 1;
    localparam int SW    = DATA_WIDTH + 1;
    localparam int OSR_N = osr_of(OSR_LOG2);
    localparam logic [OSR_LOG2-1:0] PH_LAST = OSR_LOG2'(OSR_N - 1);

    logic        [OSR_LOG2-1:0]   phase_q, phase_d;
    logic signed [AW-1:0]         acc_q, acc_d;
    logic signed [SW-1:0]         step_q, step_d;
    logic signed [DATA_WIDTH-1:0] tgt_q, tgt_d;
    logic signed [DATA_WIDTH-1:0] sbuf_q, sbuf_d;
    logic                         buf_full_q, buf_full_d;
    logic                         started_q, started_d;
    logic                         underrun_q, underrun_d;
    logic                         boundary;
    logic                         xfer;

    // Segment sequencing, accumulator ramp and one-entry input buffer.
    always_comb begin
        boundary   = (phase_q == PH_LAST);
        s_ready    = ~buf_full_q | boundary;
        xfer       = s_valid & s_ready;

        phase_d    = phase_q + 1'b1;
        // The boundary cycle still adds the old step so acc lands exactly on tgt*OSR.
        acc_d      = acc_q + {{(AW-SW){step_q[SW-1]}}, step_q};
        step_d     = step_q;
        tgt_d      = tgt_q;
        sbuf_d     = sbuf_q;
        buf_full_d = buf_full_q;
        started_d  = started_q;
        underrun_d = underrun_q;

        if (boundary) begin
            if (buf_full_q) begin
                // One extra bit keeps full-scale swings exact.
                step_d     = {sbuf_q[DATA_WIDTH-1], sbuf_q} - {tgt_q[DATA_WIDTH-1], tgt_q};
                tgt_d      = sbuf_q;
                buf_full_d = 1'b0;
            end else begin
                step_d = '0;
                if (started_q) underrun_d = 1'b1;
            end
        end

        // A same-cycle accept refills the buffer just drained above.
        if (xfer) begin
            sbuf_d     = s_data;
            buf_full_d = 1'b1;
            started_d  = 1'b1;
        end

        if (underrun_clr) underrun_d = 1'b0;
    end

    // State registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase_q    <= '0;
            acc_q      <= '0;
            step_q     <= '0;
            tgt_q      <= '0;
            sbuf_q     <= '0;
            buf_full_q <= 1'b0;
            started_q  <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            phase_q    <= phase_d;
            acc_q      <= acc_d;
            step_q     <= step_d;
            tgt_q      <= tgt_d;
            sbuf_q     <= sbuf_d;
            buf_full_q <= buf_full_d;
            started_q  <= started_d;
            underrun_q <= underrun_d;
        end
    end

    // floor(acc/OSR); always between the two segment endpoints.
    assign out_data = acc_q[OSR_LOG2+DATA_WIDTH-1:OSR_LOG2];
    assign underrun = underrun_q;

    lfsr16_dither #(
        .SEED (LFSR_SEED),
        .TAPS (LFSR_TAPS)
    ) u_dither (
        .clk    (clk),
        .rst    (rst),
        .en     (dither_en),
        .dither (out_dither)
    );

endmodule

// File: tb/tb_pcm_interp_dither.sv
// Self-checking bench for pcm_interp_dither.
module tb_pcm_interp_dither;

    logic               clk = 1'b0;
    logic               rst;
    logic signed [15:0] s_data;
    logic               s_valid;
    logic               s_ready;
    logic               dither_en;
    logic signed [15:0] out_data;
    logic               out_dither;
    logic               underrun;
    logic               underrun_clr;

    pcm_interp_dither dut (
        .clk          (clk),
        .rst          (rst),
        .s_data       (s_data),
        .s_valid      (s_valid),
        .s_ready      (s_ready),
        .dither_en    (dither_en),
        .out_data     (out_data),
        .out_dither   (out_dither),
        .underrun     (underrun),
        .underrun_clr (underrun_clr)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;
    logic signed [15:0] sb_q[$];

    typedef struct {
        int sample;
        int e1;
        int e32;
        int e63;
    } seg_t;
    seg_t tbl[8];

    task automatic check(input string nm, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, want %0d (cyc %0d)", nm, act, exp, cyc);
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic to_phase(input int p);
        while (cyc % 64 != p) tick();
    endtask

    task automatic sb_check(input string nm);
        if (sb_q.size() == 0) check({nm, "_sb_empty"}, 1, 0);
        else check(nm, out_data, sb_q.pop_front());
    endtask

    task automatic do_reset();
        rst = 1'b1; s_valid = 1'b0; s_data = '0; underrun_clr = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rst_out",    out_data,   0);
        check("rst_ready",  s_ready,    1);
        check("rst_undr",   underrun,   0);
        check("rst_dither", out_dither, dither_en);
        rst = 1'b0;
        cyc = 0;
    endtask

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return (s >> 1) ^ (s[0] ? 16'hB400 : 16'h0000);
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int prev;
        int exp;
        int cnt;
        int n_xfer;
        logic xfer;
        logic [15:0] model;
        int dexp[6];

        // Segment table: target sample and expected out_data 1, 32, 63 clks into its ramp.
        tbl[0] = '{  6400,    100,   3200,   6300};
        tbl[1] = '{ -6400,   6200,      0,  -6200};
        tbl[2] = '{     0,  -6300,  -3200,   -100};
        tbl[3] = '{    -1,     -1,     -1,     -1};
        tbl[4] = '{     0,     -1,     -1,     -1};
        tbl[5] = '{     1,      0,      0,      0};
        tbl[6] = '{ 32767,    512,  16384,  32255};
        tbl[7] = '{-32768,  31743,     -1, -31745};
        dexp = '{1, 0, 0, 0, 0, 1};

        dither_en = 1'b0;

        // ---- ramps, floor rounding, full-scale swing ----
        do_reset();
        s_valid = 1'b1; s_data = 16'(tbl[0].sample); sb_q.push_back(s_data);
        tick();
        s_valid = 1'b0;
        check("t1_ready_full", s_ready, 0);
        to_phase(63);
        check("t1_ready_bnd", s_ready, 1);
        check("t1_pre_out", out_data, 0);
        check("t1_pre_undr", underrun, 0);
        tick();
        check("t1_seg0_out", out_data, 0);
        prev = 0;
        for (int k = 0; k < 8; k++) begin
            if (k < 7) begin
                s_valid = 1'b1; s_data = 16'(tbl[k+1].sample); sb_q.push_back(s_data);
            end
            for (int n = 1; n <= 64; n++) begin
                tick();
                s_valid = 1'b0;
                exp = prev + ((n * (tbl[k].sample - prev)) >>> 6);
                check("ramp", out_data, exp);
                if (n == 1)  check("tbl_n1",  out_data, tbl[k].e1);
                if (n == 32) check("tbl_n32", out_data, tbl[k].e32);
                if (n == 63) begin
                    check("tbl_n63", out_data, tbl[k].e63);
                    check("chain_undr", underrun, 0);
                end
            end
            sb_check("seg_end");
            check("seg_undr", underrun, (k == 7) ? 1 : 0);
            prev = tbl[k].sample;
        end

        // ---- underrun clear and clear-over-set priority ----
        underrun_clr = 1'b1;
        tick();
        underrun_clr = 1'b0;
        check("clr", underrun, 0);
        to_phase(63);
        underrun_clr = 1'b1;
        tick();
        underrun_clr = 1'b0;
        check("clr_priority", underrun, 0);
        for (int i = 0; i < 64; i++) tick();
        check("reset_after_clr", underrun, 1);
        check("hold_out", out_data, -32768);

        // ---- backpressure with a counting pattern ----
        do_reset();
        cnt = 0; n_xfer = 0;
        s_valid = 1'b1; s_data = 16'(cnt * 1000 - 3000);
        for (int i = 0; i < 384; i++) begin
            check("bp_ready", s_ready, (i == 0) ? 1 : ((cyc % 64 == 63) ? 1 : 0));
            if (cyc % 64 == 0 && cyc >= 128) sb_check("bp_data");
            xfer = s_ready;
            if (xfer) begin
                sb_q.push_back(s_data);
                n_xfer++;
            end
            tick();
            if (xfer) begin
                cnt++;
                s_data = 16'(cnt * 1000 - 3000);
            end
        end
        s_valid = 1'b0;
        check("bp_count", n_xfer, 7);
        sb_q.delete();

        // ---- dither sequence and gating ----
        dither_en = 1'b1;
        do_reset();
        model = 16'hACE1;
        for (int i = 0; i < 6; i++) begin
            check("dither_seq", out_dither, dexp[i]);
            tick();
            model = lfsr_next(model);
        end
        dither_en = 1'b0;
        #1;
        for (int i = 0; i < 8; i++) begin
            check("dither_off", out_dither, 0);
            tick();
            model = lfsr_next(model);
        end
        dither_en = 1'b1;
        #1;
        for (int i = 0; i < 40; i++) begin
            check("dither_model", out_dither, model[0]);
            tick();
            model = lfsr_next(model);
        end
        dither_en = 1'b0;

        // ---- reset mid-segment ----
        do_reset();
        s_valid = 1'b1; s_data = 16'sd6400;
        tick();
        s_valid = 1'b0;
        to_phase(0);
        for (int i = 0; i < 64; i++) tick();
        check("mr_undr_set", underrun, 1);
        check("mr_hold", out_data, 6400);
        s_valid = 1'b1; s_data = -16'sd6400;
        tick();
        s_valid = 1'b0;
        to_phase(0);
        s_valid = 1'b1; s_data = 16'sd1000;
        tick();
        s_valid = 1'b0;
        to_phase(30);
        check("mr_pre_out", out_data, 400);
        check("mr_pre_ready", s_ready, 0);
        rst = 1'b1;
        tick();
        check("mr_out", out_data, 0);
        check("mr_ready", s_ready, 1);
        check("mr_undr", underrun, 0);
        rst = 1'b0;
        cyc = 0;
        for (int i = 0; i < 192; i++) begin
            check("mr_idle_undr", underrun, 0);
            check("mr_idle_out", out_data, 0);
            tick();
        end
        s_valid = 1'b1; s_data = 16'sd500;
        tick();
        s_valid = 1'b0;
        to_phase(63);
        check("mr_first_undr", underrun, 0);
        tick();
        to_phase(63);
        check("mr_ramp_out", out_data, 492);
        check("mr_ramp_undr", underrun, 0);
        tick();
        check("mr_end_out", out_data, 500);
        check("mr_end_undr", underrun, 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
